// File: rtl/regfile_sb_pkg.sv
// Shared sizing for the register file and its reservation scoreboard.
package regfile_sb_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned RNAME_W = 3;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write bits with set/clear priority, sticky protocol
// error detection and a registered busy flag.
module reg_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int unsigned W_RD = RNAME_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W_RD-1:0]      rd_name_i,
    input  logic                 rd_reserve_i,
    input  logic                 wb_v_i,
    input  logic [W_RD-1:0]      wb_name_i,
    output logic [2**W_RD-1:0]   rsv_o,
    output logic                 busy_o,
    output logic                 err_o
);

    logic [2**W_RD-1:0] rsv_q, rsv_d;
    logic               err_q, err_d;
    logic               busy_q;
    logic               same_reg;

    always_comb begin
        same_reg = (wb_name_i == rd_name_i);
        rsv_d    = rsv_q;
        err_d    = err_q;
        if (wb_v_i) begin
            rsv_d[wb_name_i] = 1'b0;
        end
        // Reserve is applied after the clear so a same-cycle WAW leaves it pending.
        if (rd_reserve_i) begin
            rsv_d[rd_name_i] = 1'b1;
        end
        if (wb_v_i && !rsv_q[wb_name_i] && !(rd_reserve_i && same_reg)) begin
            err_d = 1'b1;
        end
        if (rd_reserve_i && rsv_q[rd_name_i] && !(wb_v_i && same_reg)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsv_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            rsv_q  <= rsv_d;
            err_q  <= err_d;
            busy_q <= |rsv_d;
        end
    end

    assign rsv_o  = rsv_q;
    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, write-through bypass from
// the writeback path, and a reservation scoreboard for pending writes.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned WORD = WORD_W,
    parameter int unsigned W_RD = RNAME_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_RD-1:0]   rd_name_i,
    output logic [WORD-1:0]   rd_data_o,
    output logic              rd_reserved_o,
    input  logic [W_RD-1:0]   rs_name_i,
    output logic [WORD-1:0]   rs_data_o,
    output logic              rs_reserved_o,
    input  logic              rd_reserve_i,
    input  logic              wb_v_i,
    input  logic [W_RD-1:0]   wb_name_i,
    input  logic [WORD-1:0]   wb_data_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned NREG = 2**W_RD;

    logic [WORD-1:0] regs_q [NREG];
    logic [NREG-1:0] rsv;

    reg_scoreboard #(
        .W_RD (W_RD)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .rd_name_i    (rd_name_i),
        .rd_reserve_i (rd_reserve_i),
        .wb_v_i       (wb_v_i),
        .wb_name_i    (wb_name_i),
        .rsv_o        (rsv),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_v_i) begin
            regs_q[wb_name_i] <= wb_data_i;
        end
    end

    // A writeback in flight is visible to decode in the same cycle and never pending.
    always_comb begin
        rd_data_o     = regs_q[rd_name_i];
        rd_reserved_o = rsv[rd_name_i];
        if (wb_v_i && (wb_name_i == rd_name_i)) begin
            rd_data_o     = wb_data_i;
            rd_reserved_o = 1'b0;
        end
    end

    always_comb begin
        rs_data_o     = regs_q[rs_name_i];
        rs_reserved_o = rsv[rs_name_i];
        if (wb_v_i && (wb_name_i == rs_name_i)) begin
            rs_data_o     = wb_data_i;
            rs_reserved_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_sb;

    localparam int unsigned W  = 32;
    localparam int unsigned R  = 3;
    localparam int unsigned NR = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [R-1:0] rd_name_i, rs_name_i, wb_name_i;
    logic [W-1:0] rd_data_o, rs_data_o, wb_data_i;
    logic         rd_reserved_o, rs_reserved_o;
    logic         rd_reserve_i, wb_v_i, busy_o, err_o;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_regs [NR];
    logic         m_rsv  [NR];
    logic         m_err;
    logic         m_busy;

    always #5 clk = ~clk;

    regfile_sb #(
        .WORD (W),
        .W_RD (R)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_name_i     (rd_name_i),
        .rd_data_o     (rd_data_o),
        .rd_reserved_o (rd_reserved_o),
        .rs_name_i     (rs_name_i),
        .rs_data_o     (rs_data_o),
        .rs_reserved_o (rs_reserved_o),
        .rd_reserve_i  (rd_reserve_i),
        .wb_v_i        (wb_v_i),
        .wb_name_i     (wb_name_i),
        .wb_data_i     (wb_data_i),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    task automatic model_reset();
        for (int i = 0; i < int'(NR); i++) begin
            m_regs[i] = '0;
            m_rsv[i]  = 1'b0;
        end
        m_err  = 1'b0;
        m_busy = 1'b0;
    endtask

    function automatic logic [W-1:0] exp_data(input logic [R-1:0] n);
        return (wb_v_i && wb_name_i == n) ? wb_data_i : m_regs[n];
    endfunction

    function automatic logic exp_rsv(input logic [R-1:0] n);
        return (wb_v_i && wb_name_i == n) ? 1'b0 : m_rsv[n];
    endfunction

    task automatic drive(input logic res, input logic [R-1:0] rdn, input logic [R-1:0] rsn,
                         input logic wbv, input logic [R-1:0] wbn, input logic [W-1:0] wbd);
        rd_reserve_i = res;
        rd_name_i    = rdn;
        rs_name_i    = rsn;
        wb_v_i       = wbv;
        wb_name_i    = wbn;
        wb_data_i    = wbd;
        #1;
    endtask

    // Advance one clock edge and apply the register-file rules to the model.
    task automatic tick();
        logic pre [NR];
        @(posedge clk);
        pre = m_rsv;
        if (wb_v_i) begin
            if (!pre[wb_name_i] && !(rd_reserve_i && rd_name_i == wb_name_i)) m_err = 1'b1;
            m_regs[wb_name_i] = wb_data_i;
            m_rsv[wb_name_i]  = 1'b0;
        end
        if (rd_reserve_i) begin
            if (pre[rd_name_i] && !(wb_v_i && wb_name_i == rd_name_i)) m_err = 1'b1;
            m_rsv[rd_name_i] = 1'b1;
        end
        m_busy = 1'b0;
        for (int i = 0; i < int'(NR); i++) m_busy = m_busy | m_rsv[i];
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        model_reset();
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        drive(1'b0, 3'd3, 3'd3, 1'b0, 3'd0, '0);
        @(posedge clk);
        #1;
        checks++; if (rd_data_o !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data_o); end
        checks++; if (rs_data_o !== 32'h0) begin errors++; $display("FAIL reset_rs_data got %h exp 0", rs_data_o); end
        checks++; if (rd_reserved_o !== 1'b0) begin errors++; $display("FAIL reset_rd_rsv got %b exp 0", rd_reserved_o); end
        checks++; if (rs_reserved_o !== 1'b0) begin errors++; $display("FAIL reset_rs_rsv got %b exp 0", rs_reserved_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reserve_wb();
        drive(1'b1, 3'd2, 3'd0, 1'b0, 3'd0, '0);
        tick();
        for (int c = 1; c <= 2; c++) begin
            drive(1'b0, 3'd2, 3'd0, 1'b0, 3'd0, '0);
            checks++; if (rd_reserved_o !== 1'b1) begin errors++; $display("FAIL rsv_pending_c%0d got %b exp 1", c, rd_reserved_o); end
            checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_pending_c%0d got %b exp 1", c, busy_o); end
            tick();
        end
        drive(1'b0, 3'd2, 3'd0, 1'b1, 3'd2, 32'hDEADBEEF);
        checks++; if (rd_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_data got %h exp deadbeef", rd_data_o); end
        checks++; if (rd_reserved_o !== 1'b0) begin errors++; $display("FAIL bypass_rsv got %b exp 0", rd_reserved_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_wb_cycle got %b exp 1", busy_o); end
        tick();
        drive(1'b0, 3'd2, 3'd2, 1'b0, 3'd0, '0);
        checks++; if (rd_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL written_data got %h exp deadbeef", rd_data_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL busy_fall got %b exp 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_after_wb got %b exp 0", err_o); end
    endtask

    task automatic test_same_cycle_waw();
        drive(1'b1, 3'd5, 3'd5, 1'b1, 3'd5, 32'h12);
        checks++; if (rs_data_o !== 32'h12 || rs_reserved_o !== 1'b0) begin errors++; $display("FAIL waw_bypass got %h/%b exp 12/0", rs_data_o, rs_reserved_o); end
        tick();
        drive(1'b0, 3'd0, 3'd5, 1'b0, 3'd0, '0);
        checks++; if (rs_reserved_o !== 1'b1) begin errors++; $display("FAIL waw_rsv got %b exp 1", rs_reserved_o); end
        checks++; if (rs_data_o !== 32'h12) begin errors++; $display("FAIL waw_data got %h exp 12", rs_data_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL waw_err got %b exp 0", err_o); end
        drive(1'b0, 3'd0, 3'd5, 1'b1, 3'd5, 32'h13);
        tick();
    endtask

    task automatic test_dual_bypass();
        drive(1'b1, 3'd1, 3'd0, 1'b0, 3'd0, '0);
        tick();
        drive(1'b0, 3'd1, 3'd1, 1'b1, 3'd1, 32'h55);
        checks++; if (rd_data_o !== 32'h55 || rs_data_o !== 32'h55) begin errors++; $display("FAIL dual_data got %h/%h exp 55/55", rd_data_o, rs_data_o); end
        checks++; if (rd_reserved_o !== 1'b0 || rs_reserved_o !== 1'b0) begin errors++; $display("FAIL dual_rsv got %b/%b exp 0/0", rd_reserved_o, rs_reserved_o); end
        tick();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL dual_err got %b exp 0", err_o); end
    endtask

    task automatic test_err_sticky();
        drive(1'b0, 3'd4, 3'd4, 1'b1, 3'd4, 32'h44);
        tick();
        drive(1'b0, 3'd4, 3'd4, 1'b0, 3'd0, '0);
        checks++; if (rd_data_o !== 32'h44) begin errors++; $display("FAIL unrsv_wb_data got %h exp 44", rd_data_o); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL unrsv_wb_err got %b exp 1", err_o); end
        for (int c = 0; c < 3; c++) tick();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err_o); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 3'd6, 3'd6, 1'b0, 3'd0, '0);
        tick();
        drive(1'b0, 3'd6, 3'd6, 1'b0, 3'd0, '0);
        checks++; if (busy_o !== 1'b1 || rd_reserved_o !== 1'b1) begin errors++; $display("FAIL pre_rst got busy %b rsv %b exp 1/1", busy_o, rd_reserved_o); end
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
        checks++; if (rd_reserved_o !== 1'b0) begin errors++; $display("FAIL rst_rsv got %b exp 0", rd_reserved_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_o); end
        rst = 1'b1;
        #1;
        drive(1'b0, 3'd6, 3'd6, 1'b1, 3'd6, 32'h66);
        tick();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL post_rst_wb_err got %b exp 1", err_o); end
    endtask

    task automatic test_random();
        pulse_reset();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), R'($urandom_range(0, NR - 1)), R'($urandom_range(0, NR - 1)),
                  1'($urandom_range(0, 1)), R'($urandom_range(0, NR - 1)), $urandom);
            checks++; if (rd_data_o !== exp_data(rd_name_i) || rd_reserved_o !== exp_rsv(rd_name_i)) begin
                errors++; $display("FAIL rand_rd n=%0d got %h/%b exp %h/%b", n, rd_data_o, rd_reserved_o, exp_data(rd_name_i), exp_rsv(rd_name_i)); end
            checks++; if (rs_data_o !== exp_data(rs_name_i) || rs_reserved_o !== exp_rsv(rs_name_i)) begin
                errors++; $display("FAIL rand_rs n=%0d got %h/%b exp %h/%b", n, rs_data_o, rs_reserved_o, exp_data(rs_name_i), exp_rsv(rs_name_i)); end
            tick();
            checks++; if (busy_o !== m_busy || err_o !== m_err) begin
                errors++; $display("FAIL rand_state n=%0d got busy %b err %b exp %b %b", n, busy_o, err_o, m_busy, m_err); end
            if (n % 50 == 49) pulse_reset();
        end
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        test_reset();
        test_reserve_wb();
        test_same_cycle_waw();
        test_dual_bypass();
        test_err_sticky();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
